// File: rtl/axi_rr_arbiter3_if.sv
// Handshake bundle between up to three channel managers and the round-robin arbiter.
// The slave modport is the arbiter; the master modport is the manager side.
interface axi_rr_arbiter3_if;
  logic       req0;
  logic       req1;
  logic       req2;
  logic       finish0;
  logic       finish1;
  logic       finish2;
  logic       gnt0;
  logic       gnt1;
  logic       gnt2;
  logic [2:0] sel;
  logic       busy;
  logic       tout_err;
  logic [1:0] tout_id;

  modport slave (
    input  req0, req1, req2, finish0, finish1, finish2,
    output gnt0, gnt1, gnt2, sel, busy, tout_err, tout_id
  );

  modport master (
    output req0, req1, req2, finish0, finish1, finish2,
    input  gnt0, gnt1, gnt2, sel, busy, tout_err, tout_id
  );
endinterface

// File: rtl/axi_rr_arbiter3.sv
// Round-robin, grant-until-finish arbiter for a shared AXI channel with three managers.
// An ownership watchdog forcibly releases a stuck owner and reports which one it was.
module axi_rr_arbiter3 #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  axi_rr_arbiter3_if.slave bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StGrant   = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic             WdogEn  = (TIMEOUT != 0);

  logic [1:0]       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_err_q, tout_err_d;
  logic [1:0]       tout_id_q, tout_id_d;

  logic [2:0] req;
  logic [2:0] fin;
  logic       any_req;
  logic [1:0] win_idx;
  logic [1:0] owner_idx;
  logic       owner_fin;
  logic       expire;

  assign req = {bus.req2, bus.req1, bus.req0};
  assign fin = {bus.finish2, bus.finish1, bus.finish0};
  assign any_req = |req;

  // Scan last+3 down to last+1 so the candidate right after the last winner overrides the rest.
  always_comb begin
    logic [2:0] sum;
    logic [1:0] cand;
    win_idx = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      sum  = {1'b0, last_q} + 3'(k);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (req[cand]) begin
        win_idx = cand;
      end
    end
  end

  assign owner_idx = sel_q[1] ? 2'd1 : (sel_q[2] ? 2'd2 : 2'd0);
  assign owner_fin = |(sel_q & fin);
  assign expire    = WdogEn && (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    tout_err_d = 1'b0;
    tout_id_d  = tout_id_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          sel_d   = 3'b001 << win_idx;
          last_d  = win_idx;
          cnt_d   = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // An owner finish on the expiry cycle wins over the watchdog.
        if (owner_fin) begin
          sel_d   = 3'b000;
          state_d = StRelease;
        end else if (expire) begin
          sel_d      = 3'b000;
          state_d    = StRelease;
          tout_err_d = 1'b1;
          tout_id_d  = owner_idx;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        sel_d   = 3'b000;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= 3'b000;
      last_q     <= 2'd2;
      cnt_q      <= '0;
      tout_err_q <= 1'b0;
      tout_id_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      tout_err_q <= tout_err_d;
      tout_id_q  <= tout_id_d;
    end
  end

  assign bus.gnt0     = sel_q[0];
  assign bus.gnt1     = sel_q[1];
  assign bus.gnt2     = sel_q[2];
  assign bus.sel      = sel_q;
  assign bus.busy     = |sel_q;
  assign bus.tout_err = tout_err_q;
  assign bus.tout_id  = tout_id_q;

endmodule

// File: tb/tb_axi_rr_arbiter3.sv
// Self-checking bench for axi_rr_arbiter3: directed scenarios plus randomized traffic
// compared cycle by cycle against an ownership-level reference model.
module tb_axi_rr_arbiter3;
  localparam int unsigned TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] fin = 3'b000;
  int         total = 0;
  int         bad = 0;

  // Reference model: who owns the channel, for how long, and how many dead cycles remain.
  int         m_owner;
  int         m_hold;
  int         m_cool;
  int         m_last;
  logic       m_err;
  int         m_id;

  axi_rr_arbiter3_if bus ();

  assign bus.req0    = req[0];
  assign bus.req1    = req[1];
  assign bus.req2    = req[2];
  assign bus.finish0 = fin[0];
  assign bus.finish1 = fin[1];
  assign bus.finish2 = fin[2];

  axi_rr_arbiter3 #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wire [9:0] dut_vec = {bus.gnt2, bus.gnt1, bus.gnt0, bus.sel, bus.busy, bus.tout_err,
                        bus.tout_id};

  function automatic logic [9:0] exp_vec();
    logic [2:0] s;
    s = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    return {s, s, |s, m_err, 2'(m_id)};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_cool  = 0;
    m_last  = 2;
    m_err   = 1'b0;
    m_id    = 0;
  endtask

  // One clock edge; the model consumes the inputs that were stable across it.
  task automatic tick();
    @(posedge clk);
    m_err = 1'b0;
    if (m_owner >= 0) begin
      if (fin[m_owner]) begin
        m_owner = -1;
        m_cool  = 1;
      end else if (TIMEOUT != 0 && m_hold == int'(TIMEOUT) - 1) begin
        m_err   = 1'b1;
        m_id    = m_owner;
        m_owner = -1;
        m_cool  = 1;
      end else begin
        m_hold++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        if (m_owner < 0 && req[(m_last + k) % 3]) begin
          m_owner = (m_last + k) % 3;
          m_last  = m_owner;
          m_hold  = 0;
        end
      end
    end
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (bus.sel === 3'b000 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 3'b000;
    fin   = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (dut_vec !== 10'b0) begin
      bad++;
      $display("FAIL reset: got %b want %b", dut_vec, 10'b0);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 3'b001;
    tick();
    total++;
    if (bus.gnt0 !== 1'b1 || bus.sel !== 3'b001 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL single_grant: got %b want %b", dut_vec, exp_vec());
    end
    req = 3'b000;
    tick();
    fin = 3'b001;
    tick();
    fin = 3'b000;
    total++;
    if (bus.sel !== 3'b000 || bus.busy !== 1'b0 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL single_release: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    int n;
    apply_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(n);
      total++;
      if (bus.sel !== order[i] || (i > 0 && n + 1 != 3)) begin
        bad++;
        $display("FAIL rr_order[%0d]: got sel=%b gap=%0d want sel=%b gap=3", i, bus.sel, n + 1,
                 order[i]);
      end
      repeat (3) tick();
      fin = bus.sel;
      tick();
      fin = 3'b000;
    end
    req = 3'b000;
    repeat (3) tick();
    total++;
    if (dut_vec !== exp_vec() || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_idle: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_foreign_finish();
    int n;
    apply_reset();
    req = 3'b010;
    wait_grant(n);
    req = 3'b000;
    fin = 3'b101;
    tick();
    fin = 3'b000;
    total++;
    if (bus.gnt1 !== 1'b1 || bus.sel !== 3'b010 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL foreign_finish: got %b want gnt1 held", dut_vec);
    end
    tick();
    fin = 3'b010;
    tick();
    fin = 3'b000;
    total++;
    if (bus.sel !== 3'b000 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL owner_finish: got %b want %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_timeout();
    int n;
    int held;
    int pulses;
    apply_reset();
    req = 3'b100;
    wait_grant(n);
    req = 3'b001;
    held = 0;
    pulses = 0;
    while (bus.gnt2 === 1'b1 && held < 30) begin
      tick();
      held++;
    end
    total++;
    if (held != 8 || bus.tout_err !== 1'b1 || bus.tout_id !== 2'd2) begin
      bad++;
      $display("FAIL timeout_fire: got held=%0d err=%b id=%0d want 8 1 2", held, bus.tout_err,
               bus.tout_id);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.tout_err === 1'b1) pulses++;
      tick();
    end
    total++;
    if (pulses != 1 || bus.sel !== 3'b001 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL timeout_next: got pulses=%0d sel=%b want 1 001", pulses, bus.sel);
    end
    req = 3'b000;
    fin = 3'b001;
    tick();
    fin = 3'b000;
  endtask

  task automatic test_finish_on_expiry();
    int n;
    int errs;
    apply_reset();
    req = 3'b010;
    wait_grant(n);
    req = 3'b000;
    repeat (7) tick();
    total++;
    if (bus.gnt1 !== 1'b1 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL expiry_hold: got %b want %b", dut_vec, exp_vec());
    end
    fin = 3'b010;
    tick();
    fin = 3'b000;
    errs = (bus.tout_err === 1'b1) ? 1 : 0;
    tick();
    if (bus.tout_err === 1'b1) errs++;
    total++;
    if (errs != 0 || bus.sel !== 3'b000 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL expiry_finish: got errs=%0d vec=%b want 0 %b", errs, dut_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    int n;
    apply_reset();
    req = 3'b001;
    wait_grant(n);
    req = 3'b000;
    fin = 3'b001;
    tick();
    fin = 3'b000;
    req = 3'b010;
    wait_grant(n);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec[9:3] !== 7'b0) begin
      bad++;
      $display("FAIL async_reset: got gnt/sel/busy=%b want 0", dut_vec[9:3]);
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    req = 3'b110;
    rst_n = 1'b1;
    wait_grant(n);
    total++;
    if (bus.sel !== 3'b010 || dut_vec !== exp_vec()) begin
      bad++;
      $display("FAIL reset_priority: got sel=%b want 010", bus.sel);
    end
    req = 3'b000;
    fin = 3'b010;
    tick();
    fin = 3'b000;
  endtask

  task automatic test_random();
    int waits [3];
    logic [2:0] held_req;
    logic prev_busy;
    int w;
    int fails;
    apply_reset();
    waits = '{0, 0, 0};
    fails = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && m_owner == i && $urandom_range(0, 1) == 1) req[i] = 1'b0;
      end
      fin = 3'b000;
      if (m_owner >= 0 && $urandom_range(0, 5) == 0) fin[m_owner] = 1'b1;
      if ($urandom_range(0, 9) == 0) fin[$urandom_range(0, 2)] = 1'b1;
      held_req  = req;
      prev_busy = bus.busy;
      tick();
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++;
        fails++;
        if (fails < 10) $display("FAIL random[%0d]: got %b want %b", c, dut_vec, exp_vec());
      end
      if (bus.busy === 1'b1 && prev_busy === 1'b0) begin
        w = bus.sel[1] ? 1 : (bus.sel[2] ? 2 : 0);
        for (int i = 0; i < 3; i++) begin
          if (i == w) waits[i] = 0;
          else if (held_req[i]) waits[i]++;
        end
        total++;
        if (waits[0] > 2 || waits[1] > 2 || waits[2] > 2) begin
          bad++;
          $display("FAIL fairness[%0d]: got waits=%0d,%0d,%0d want <=2", c, waits[0], waits[1],
                   waits[2]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (!req[i]) waits[i] = 0;
      end
    end
    req = 3'b000;
    fin = 3'b000;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_foreign_finish();
    test_timeout();
    test_finish_on_expiry();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
